// File: rtl/tile_rom_server_pkg.sv
// -----------------------------------------------------------------------------
// tile_rom_server_pkg
// Shared definitions for the tile ROM responder. It holds the default address
// widths, the SDRAM offset of the tile ROM region, and the fetch FSM state type.
// -----------------------------------------------------------------------------
package tile_rom_server_pkg;

  localparam int TILE_ADDR_W = 18;
  localparam int TILE_SDR_AW = 24;
  localparam logic [TILE_SDR_AW-1:0] TILE_SDR_BASE = 24'h080000;

  // The fetch FSM. RESYNC after reset is a condition of IDLE: the state stays
  // IDLE and no request is issued while ack differs from req.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage : tile_rom_server_pkg

// File: rtl/tile_rom_server.sv
// -----------------------------------------------------------------------------
// tile_rom_server
// This block answers tile ROM reads from the scroll plane. It keeps one fetched
// 32-bit word and the address that word belongs to. When the plane asks for a
// different address, or the held word was invalidated, it fetches the new word
// from SDRAM through a toggle req/ack port. While a ROM download is running, it
// issues no fetches.
//
// Ports
//   clk, reset   system clock; asynchronous active-high reset
//   rom_addr     tile ROM word address from the plane block
//   rom_dout     held ROM word (registered; changes only on fetch or reset)
//   rom_valid    rom_dout belongs to the current rom_addr
//   dl_busy      ROM download in progress; blocks fetches and invalidates
//   sdr_addr     SDRAM word address = SDR_BASE + rom_addr, wrapping at SDR_AW bits
//   sdr_req      toggle request
//   sdr_ack      toggle acknowledge
//   sdr_dout     SDRAM read data, valid in the cycle ack matches req
//   miss_count   saturating count of issued fetches
//   dbg_state    current fetch FSM state
//
// Handshake: a fetch is outstanding when sdr_ack != sdr_req. To issue a fetch,
// this block sets sdr_addr and toggles sdr_req in the same cycle. It then keeps
// both stable until the responder sets sdr_ack equal to sdr_req. sdr_dout is
// captured in that same cycle.
// -----------------------------------------------------------------------------
module tile_rom_server
  import tile_rom_server_pkg::*;
#(
  parameter int                ADDR_W   = tile_rom_server_pkg::TILE_ADDR_W,
  parameter int                SDR_AW   = tile_rom_server_pkg::TILE_SDR_AW,
  parameter logic [SDR_AW-1:0] SDR_BASE = tile_rom_server_pkg::TILE_SDR_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_dout,
  output logic              rom_valid,
  input  logic              dl_busy,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [31:0]       sdr_dout,
  output logic [15:0]       miss_count,
  output state_t            dbg_state
);

  state_t              state_q, state_d;
  logic                sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0]   sdr_addr_q, sdr_addr_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]   held_addr_q, held_addr_d;
  logic                held_ok_q, held_ok_d;
  logic [31:0]         rom_dout_q, rom_dout_d;
  logic [15:0]         miss_count_q, miss_count_d;

  logic                ack_match;
  logic                held_hit;

  assign ack_match = (sdr_ack == sdr_req_q);
  assign held_hit  = held_ok_q && (rom_addr == held_addr_q);

  always_comb begin
    state_d      = state_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    fetch_addr_d = fetch_addr_q;
    held_addr_d  = held_addr_q;
    held_ok_d    = held_ok_q;
    rom_dout_d   = rom_dout_q;
    miss_count_d = miss_count_q;

    case (state_q)
      IDLE: begin
        if (dl_busy) begin
          // Data may be rewritten by the download, so the held word is
          // treated as invalid.
          held_ok_d = 1'b0;
        end else if (ack_match && !held_hit) begin
          // If ack_match is low here, a stale ack is left over from before
          // reset. The block waits for the responder to resync before it
          // issues anything.
          fetch_addr_d = rom_addr;
          sdr_addr_d   = SDR_BASE + SDR_AW'(rom_addr);
          sdr_req_d    = ~sdr_req_q;
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A fetch is never cancelled. If rom_addr changed meanwhile, IDLE
        // sees the mismatch and issues again.
        if (ack_match) begin
          rom_dout_d  = sdr_dout;
          held_addr_d = fetch_addr_q;
          held_ok_d   = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      fetch_addr_q <= '0;
      held_addr_q  <= '0;
      held_ok_q    <= 1'b0;
      rom_dout_q   <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      fetch_addr_q <= fetch_addr_d;
      held_addr_q  <= held_addr_d;
      held_ok_q    <= held_ok_d;
      rom_dout_q   <= rom_dout_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign rom_valid  = held_hit && !dl_busy;
  assign rom_dout   = rom_dout_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_req    = sdr_req_q;
  assign miss_count = miss_count_q;
  assign dbg_state  = state_q;

endmodule : tile_rom_server

// File: tb/tb_tile_rom_server.sv
// -----------------------------------------------------------------------------
// tb_tile_rom_server
// Directed bench for tile_rom_server. Each time the bench drives a new address,
// it pushes the SDRAM address it expects into exp_q. A monitor compares sdr_addr
// with that queue on every sdr_req toggle. A small SDRAM responder acks after
// ack_delay cycles and returns data_fn(address).
// -----------------------------------------------------------------------------
module tb_tile_rom_server;
  import tile_rom_server_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] rom_addr;
  logic [31:0] rom_dout;
  logic        rom_valid;
  logic        dl_busy;
  logic [23:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack;
  logic [31:0] sdr_dout;
  logic [15:0] miss_count;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];

  bit model_en  = 1'b1;
  int ack_delay = 5;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tile_rom_server dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .rom_valid  (rom_valid),
    .dl_busy    (dl_busy),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_dout   (sdr_dout),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- helpers ----------------
  function automatic logic [31:0] data_fn(input logic [23:0] a);
    return 32'hDEADBEEF ^ {8'h00, a ^ 24'h080010};
  endfunction

  function automatic logic [23:0] sdr_of(input logic [17:0] a);
    return 24'h080000 + {6'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!rom_valid && cyc < 60);
    if (!rom_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: rom_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_miss(input string name, input logic [15:0] target);
    int cyc;
    cyc = 0;
    while (miss_count !== target && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
    end
    check(name, 32'(miss_count), 32'(target));
  endtask

  // ---------------- SDRAM responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (model_en && !reset && (sdr_req != sdr_ack)) begin
        cnt++;
        if (cnt >= ack_delay) begin
          sdr_dout = data_fn(sdr_addr);
          sdr_ack  = sdr_req;
          cnt      = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic        prev_req;
    logic [23:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        prev_req = sdr_req;
      end else begin
        if (sdr_req !== prev_req) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got sdr_addr %h expected no request", sdr_addr);
          end else begin
            e = exp_q.pop_front();
            check("req_addr", 32'(sdr_addr), 32'(e));
          end
        end
        prev_req = sdr_req;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    logic [17:0] sat_addr[4];
    logic [15:0] sat_exp[4];

    reset    = 1'b1;
    rom_addr = 18'h00010;
    dl_busy  = 1'b0;
    sdr_ack  = 1'b0;
    sdr_dout = 32'h0;

    // Reset values
    tick(2); #1;
    check("rst_rom_dout", rom_dout, 32'h0);
    check("rst_rom_valid", 32'(rom_valid), 32'h0);
    check("rst_sdr_req", 32'(sdr_req), 32'h0);
    check("rst_sdr_addr", 32'(sdr_addr), 32'h0);
    check("rst_miss", 32'(miss_count), 32'h0);

    // First fetch: request goes out 1 cycle after reset is released, the
    // ack comes 5 negedges later, and the data is held 1 cycle after that.
    tick(1);
    exp_q.push_back(24'h080010);
    reset = 1'b0;
    wait_valid("first_valid", lat);
    check("first_latency", 32'(lat), 32'd6);
    check("first_dout", rom_dout, 32'hDEADBEEF);
    check("first_miss", 32'(miss_count), 32'd1);

    // Holding the same address must not cause another fetch.
    tick(100); #1;
    check("hold_miss", 32'(miss_count), 32'd1);
    check("hold_valid", 32'(rom_valid), 32'd1);
    check("hold_dout", rom_dout, 32'hDEADBEEF);

    // Address changes while a fetch is outstanding.
    tick(1);
    rom_addr = 18'h00020;
    exp_q.push_back(24'h080020);
    tick(2);
    rom_addr = 18'h00021;
    exp_q.push_back(24'h080021);
    wait_miss("chg_miss", 16'd3);
    check("chg_valid_low", 32'(rom_valid), 32'd0);
    check("chg_dout_old", rom_dout, data_fn(24'h080020));
    check("chg_sdr_addr", 32'(sdr_addr), 32'h080021);
    wait_valid("chg_valid", lat);
    check("chg_dout_new", rom_dout, data_fn(24'h080021));

    // Address goes back to the held address while a fetch is outstanding.
    tick(1);
    rom_addr = 18'h00030;
    exp_q.push_back(24'h080030);
    tick(2);
    rom_addr = 18'h00021;
    exp_q.push_back(24'h080021);
    #1;
    check("ret_valid_now", 32'(rom_valid), 32'd1);
    check("ret_dout_now", rom_dout, data_fn(24'h080021));
    wait_miss("ret_miss", 16'd5);
    check("ret_dout_over", rom_dout, data_fn(24'h080030));
    check("ret_valid_low", 32'(rom_valid), 32'd0);
    wait_valid("ret_valid", lat);
    check("ret_dout_refetch", rom_dout, data_fn(24'h080021));

    // dl_busy goes high during WAIT: the fetch completes, then held data is dropped.
    tick(1);
    rom_addr = 18'h00040;
    exp_q.push_back(24'h080040);
    tick(2);
    dl_busy = 1'b1;
    #1;
    check("busyw_valid", 32'(rom_valid), 32'd0);
    tick(10); #1;
    check("busyw_dout", rom_dout, data_fn(24'h080040));
    check("busyw_miss", 32'(miss_count), 32'd6);
    check("busyw_state", 32'(dbg_state), 32'(IDLE));
    tick(1);
    dl_busy = 1'b0;
    exp_q.push_back(24'h080040);
    tick(1); #1;
    check("busyw_refetch_miss", 32'(miss_count), 32'd7);
    wait_valid("busyw_valid_again", lat);

    // dl_busy held for 50 cycles while the address keeps moving.
    tick(1);
    dl_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rom_addr = 18'h00100 + 18'(i);
      tick(1);
    end
    #1;
    check("busy_miss", 32'(miss_count), 32'd7);
    check("busy_valid", 32'(rom_valid), 32'd0);
    tick(1);
    dl_busy = 1'b0;
    exp_q.push_back(24'h080131);
    tick(1); #1;
    check("busy_fall_miss", 32'(miss_count), 32'd8);
    check("busy_fall_addr", 32'(sdr_addr), 32'h080131);
    wait_valid("busy_fall_valid", lat);
    check("busy_fall_dout", rom_dout, data_fn(24'h080131));

    // Saturation: preload the counter near its limit during an idle hit.
    ack_delay = 1;
    tick(1);
    force dut.miss_count_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.miss_count_q;
    #1;
    check("sat_preload", 32'(miss_count), 32'h0000FFFD);
    sat_addr[0] = 18'h00200; sat_exp[0] = 16'hFFFE;
    sat_addr[1] = 18'h00201; sat_exp[1] = 16'hFFFF;
    sat_addr[2] = 18'h3FFFF; sat_exp[2] = 16'hFFFF;
    sat_addr[3] = 18'h00000; sat_exp[3] = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      rom_addr = sat_addr[k];
      exp_q.push_back(sdr_of(sat_addr[k]));
      wait_valid("sat_valid", lat);
      check("sat_miss", 32'(miss_count), 32'(sat_exp[k]));
      check("sat_dout", rom_dout, data_fn(sdr_of(sat_addr[k])));
    end

    // Reset while in WAIT when the ack never arrives, followed by a stale ack.
    tick(1);
    model_en = 1'b0;
    ack_delay = 3;
    rom_addr = 18'h00300;
    exp_q.push_back(24'h080300);
    tick(2);
    reset   = 1'b1;
    sdr_ack = 1'b1;
    #1;
    check("mrst_req", 32'(sdr_req), 32'd0);
    check("mrst_dout", rom_dout, 32'h0);
    check("mrst_valid", 32'(rom_valid), 32'd0);
    check("mrst_miss", 32'(miss_count), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    tick(2);
    reset = 1'b0;
    tick(5); #1;
    check("resync_req", 32'(sdr_req), 32'd0);
    check("resync_miss", 32'(miss_count), 32'd0);
    check("resync_state", 32'(dbg_state), 32'(IDLE));
    tick(1);
    sdr_ack = 1'b0;
    exp_q.push_back(24'h080300);
    tick(1); #1;
    check("resync_issue_req", 32'(sdr_req), 32'd1);
    check("resync_issue_miss", 32'(miss_count), 32'd1);
    model_en = 1'b1;
    wait_valid("resync_valid", lat);
    check("resync_dout", rom_dout, data_fn(24'h080300));

    tick(5); #1;
    check("pending_requests", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tile_rom_server
